// File: rtl/mem_access_pkg.sv
// Shared encodings for the word-wide memory access unit.
// Sizes, FSM states and the lane width used by mem_access_unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int LANE_W = 8;
    localparam int WORD_W = 4 * LANE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Size 2'b11 falls through to the word case everywhere.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic mis;
        mis = 1'b0;
        unique case (1'b1)
            size == SIZE_BYTE: mis = 1'b0;
            size == SIZE_HALF: mis = lo[0];
            default:           mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction for loads and lane merging for
// sub-word stores; purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] new_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;
    logic [LANE_W-1:0]   byte_v;
    logic [2*LANE_W-1:0] half_v;

    // A half ignores addr[0]; only addr[1] picks the half lane.
    assign byte_sh = {lane, 3'b000};
    assign half_sh = {lane[1], 4'b0000};
    assign byte_v  = word[byte_sh +: LANE_W];
    assign half_v  = word[half_sh +: 2*LANE_W];

    always_comb begin
        load_data = word;
        unique case (1'b1)
            size == SIZE_BYTE:
                load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
            size == SIZE_HALF:
                load_data = {{16{sign_ext & half_v[15]}}, half_v};
            default:
                load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        unique case (1'b1)
            size == SIZE_BYTE:
                merged[byte_sh +: LANE_W] = new_data[LANE_W-1:0];
            size == SIZE_HALF:
                merged[half_sh +: 2*LANE_W] = new_data[2*LANE_W-1:0];
            default:
                merged = new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bridge to a word-wide memory; sub-word stores use RMW.
// Optional misalignment trap: define MEM_ALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              align_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_t state;
    state_t state_nx;

    logic        trap;
    logic        ld_addr;
    logic        ld_wdata;
    logic        ld_merge;
    logic        ld_rdata;
    logic [31:0] load_data;
    logic [31:0] merged;

    mem_lane_align u_align (
        .word      (mem_rdata),
        .size      (req_size),
        .lane      (req_addr[1:0]),
        .sign_ext  (req_signed),
        .new_data  (req_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

`ifdef MEM_ALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign stall = req_valid && (state != ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld_addr  = 1'b0;
        ld_wdata = 1'b0;
        ld_merge = 1'b0;
        ld_rdata = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    ld_addr = 1'b1;
                    if (trap) begin
                        state_nx = ST_DONE;
                    end else if (!req_write) begin
                        state_nx = ST_LOAD;
                    end else if (is_word(req_size)) begin
                        ld_wdata = 1'b1;
                        state_nx = ST_WRITE;
                    end else begin
                        state_nx = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                ld_rdata = 1'b1;
                state_nx = ST_DONE;
            end
            ST_MERGE: begin
                ld_merge = 1'b1;
                state_nx = ST_WRITE;
            end
            ST_WRITE: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Strobe is decoded from the next state so it is a clean register
    // output, rising and falling on the same edges as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
        end else begin
            if (ld_addr) begin
                mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            if (ld_wdata) begin
                mem_wdata <= req_wdata;
            end else if (ld_merge) begin
                mem_wdata <= merged;
            end
            if (ld_rdata) begin
                rdata <= load_data;
            end
            mem_write <= (state_nx == ST_WRITE);
        end
    end

`ifdef MEM_ALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err <= 1'b0;
        end else begin
            align_err <= (state == ST_IDLE) && req_valid && trap;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-level reference model
// and a per-cycle compare process.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        align_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic        preload = 1'b1;
    logic [31:0] mem [16];
    logic [31:0] model_mem [16];

    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_word = '0;
    int          exp_stall = 0;
    int          exp_wr = 0;
    logic        exp_align = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .align_err  (align_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 32'h8899AABB;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
    endfunction

    function automatic int base_of(input logic [1:0] sz, input logic [1:0] a);
        int nb;
        nb = nbytes(sz);
        return (nb == 4) ? 0 : (int'(a) / nb) * nb;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w,
        input logic [1:0] sz, input logic [1:0] a, input logic sg);
        longint unsigned lim, v;
        lim = 64'd1 << (8 * nbytes(sz));
        v = ({32'd0, w} >> (8 * base_of(sz, a))) % lim;
        if (sg && nbytes(sz) < 4 && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old,
        input logic [31:0] d, input logic [1:0] sz, input logic [1:0] a);
        longint unsigned lim, mask, res;
        lim = 64'd1 << (8 * nbytes(sz));
        mask = (lim - 1) << (8 * base_of(sz, a));
        res = ({32'd0, old} & ~mask) | (({32'd0, d} << (8 * base_of(sz, a))) & mask);
        return res[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            wr_cnt = 0;
            chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_align_err", {31'd0, align_err}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
        end else if (req_valid) begin
            if (stall_cnt > 0) chk("mem_addr", mem_addr, exp_addr);
            if (mem_write) begin
                wr_cnt++;
                chk("wr_data", mem_wdata, exp_word);
            end
            if (stall) begin
                stall_cnt++;
                if (stall_cnt > 6) chk("timeout", 32'(stall_cnt), 32'(exp_stall));
                chk("align_early", {31'd0, align_err}, 32'd0);
            end else begin
                chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
                chk("write_pulses", 32'(wr_cnt), 32'(exp_wr));
                chk("align_err", {31'd0, align_err}, {31'd0, exp_align});
                chk("rdata_done", rdata, exp_rdata);
                if (exp_wr != 0) chk("done_wdata", mem_wdata, exp_word);
                stall_cnt = 0;
                wr_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
            wr_cnt = 0;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_write", {31'd0, mem_write}, 32'd0);
            chk("idle_align", {31'd0, align_err}, 32'd0);
            chk("idle_rdata", rdata, exp_rdata);
            for (int i = 0; i < 4; i++)
                chk($sformatf("mem%0d", i), mem[i], model_mem[i]);
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
        input logic [31:0] a, input logic [31:0] d, input logic use_lit,
        input logic [31:0] lit);
        logic [31:0] old;
        logic        mis;
        int          idx;
        idx = int'(a[5:2]);
        old = model_mem[idx];
        mis = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
        mis = (nbytes(sz) == 2 && a[0]) || (nbytes(sz) == 4 && a[1:0] != 2'b00);
`endif
        @(posedge clk);
        #1;
        exp_addr = {a[31:2], 2'b00};
        exp_align = mis;
        if (mis) begin
            exp_stall = 1;
            exp_wr = 0;
        end else if (w) begin
            exp_word = use_lit ? lit : m_store(old, d, sz, a[1:0]);
            model_mem[idx] = exp_word;
            exp_wr = 1;
            exp_stall = (nbytes(sz) == 4) ? 2 : 3;
        end else begin
            exp_rdata = use_lit ? lit : m_load(old, sz, a[1:0], sg);
            exp_wr = 0;
            exp_stall = 2;
        end
        req_write = w;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stall) break;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_mem[0] = 32'h8899AABB;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_req(0, SIZE_WORD, 0, 32'h1000, 0, 1, 32'h8899AABB);
        do_req(0, SIZE_BYTE, 1, 32'h1001, 0, 1, 32'hFFFFFFAA);
        do_req(0, SIZE_BYTE, 0, 32'h1003, 0, 1, 32'h00000088);
        do_req(0, SIZE_BYTE, 0, 32'h1000, 0, 1, 32'h000000BB);
        do_req(0, SIZE_WORD, 1, 32'h1001, 0, 1, 32'h8899AABB);

        do_req(1, SIZE_BYTE, 0, 32'h1002, 32'h12345677, 1, 32'h8877AABB);
        do_req(1, SIZE_HALF, 0, 32'h1002, 32'h0000CAFE, 1, 32'hCAFEAABB);
        do_req(0, SIZE_HALF, 1, 32'h1002, 0, 1, 32'hFFFFCAFE);
        do_req(0, SIZE_HALF, 0, 32'h1000, 0, 1, 32'h0000AABB);

        for (int k = 0; k < 8; k++)
            do_req(0, SIZE_BYTE, k[0], 32'h1000 + 32'(k >> 1), 0, 0, 0);
        do_req(1, 2'b11, 0, 32'h1004, 32'h0BADF00D, 0, 0);
        do_req(1, SIZE_BYTE, 0, 32'h1007, 32'hFFFFFFAB, 1, 32'hABADF00D);
        do_req(0, SIZE_BYTE, 1, 32'h1007, 0, 1, 32'hFFFFFFAB);
        do_req(0, 2'b11, 1, 32'h1004, 0, 1, 32'hABADF00D);

        // Word store to 0x1008, cut off by reset while the strobe is high.
        @(posedge clk);
        #1;
        exp_addr = 32'h1008;
        exp_word = 32'hDEADBEEF;
        exp_wr = 1;
        exp_stall = 2;
        req_write = 1'b1;
        req_size = SIZE_WORD;
        req_addr = 32'h1008;
        req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        exp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_req(1, SIZE_WORD, 0, 32'h1000, 32'h13579BDF, 1, 32'h13579BDF);
        do_req(0, SIZE_WORD, 0, 32'h1000, 0, 1, 32'h13579BDF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
